downlink_receiver: RTL and testbench

- Receives the AGC serial telemetry downlink and reassembles each 40-bit downlink frame into its channel 34 and channel 35 words plus a sync byte.
- Sits on the simulation side of the AGC model, opposite the stimulus driver. The driver writes the AGC inputs; this block reads the AGC downlink pins and presents parallel words to the bench or a logger.
- Internal logic runs on CLOCK. The downlink lines are asynchronous and are synchronized internally.

---
 rtl/downlink_receiver.sv | 133 +++++++++++++
 tb/tb_downlink_receiver.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/downlink_receiver.sv
// downlink_receiver: reassembles 40-bit AGC downlink frames into CH34/CH35 words plus sync check.
// Optional frame counters (GOOD_CNT, ERR_CNT) are enabled by defining DLRX_FRMCNT_EN.
module downlink_receiver #(
  parameter int WORD_BITS = 16,
  parameter int SYNC_BITS = 8,
  parameter logic [SYNC_BITS-1:0] SYNC_PAT = 8'hA5,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 CLOCK,
  input  logic                 SIM_RST_n,
  input  logic                 DKSTRT,
  input  logic                 DKBSNC,
  input  logic                 DKDATA_n,
  input  logic                 DKEND,
  output logic [WORD_BITS-1:0] CH34_OUT,
  output logic [WORD_BITS-1:0] CH35_OUT,
  output logic                 WORD_ORDER,
  output logic                 WORD_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
`ifdef DLRX_FRMCNT_EN
  ,
  output logic [7:0]           GOOD_CNT,
  output logic [7:0]           ERR_CNT
`endif
);
  localparam int N = 2*WORD_BITS + SYNC_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] NC = CW'(N);
  localparam logic [TW-1:0] TL = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state;
  logic [2:0] st_s, bs_s, en_s;
  logic [1:0] dat_s;
  logic ev_st, ev_bs, ev_en, bit_in;
  logic [N-1:0] sr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  assign BUSY = (state != IDLE);
  // two sync flops, a history flop for edge detection, then a registered event
  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      st_s   <= '0;
      bs_s   <= '0;
      en_s   <= '0;
      dat_s  <= '1;
      ev_st  <= 1'b0;
      ev_bs  <= 1'b0;
      ev_en  <= 1'b0;
      bit_in <= 1'b0;
    end else begin
      st_s   <= {st_s[1:0], DKSTRT};
      bs_s   <= {bs_s[1:0], DKBSNC};
      en_s   <= {en_s[1:0], DKEND};
      dat_s  <= {dat_s[0], DKDATA_n};
      ev_st  <= st_s[1] & ~st_s[2];
      ev_bs  <= bs_s[1] & ~bs_s[2];
      ev_en  <= en_s[1] & ~en_s[2];
      bit_in <= ~dat_s[1];
    end
  end
  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      CH34_OUT   <= '0;
      CH35_OUT   <= '0;
      WORD_ORDER <= 1'b0;
      WORD_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      WORD_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      case (state)
        IDLE: if (ev_st) begin
          sr    <= '0;
          cnt   <= '0;
          tcnt  <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (ev_st) begin
            sr        <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            FRAME_ERR <= 1'b1;
          end else if (ev_en) begin
            state <= CHECK;
          end else if (ev_bs) begin
            if (cnt == NC) begin
              FRAME_ERR <= 1'b1;
              state     <= IDLE;
            end else begin
              sr   <= {sr[N-2:0], bit_in};
              cnt  <= cnt + 1'b1;
              tcnt <= '0;
            end
          end else if (tcnt == TL) begin
            FRAME_ERR <= 1'b1;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          if (cnt == NC && sr[SYNC_BITS-1:0] == SYNC_PAT) begin
            CH34_OUT   <= sr[N-1 -: WORD_BITS];
            CH35_OUT   <= sr[SYNC_BITS +: WORD_BITS];
            WORD_ORDER <= sr[N-1];
            WORD_VALID <= 1'b1;
          end else begin
            FRAME_ERR <= 1'b1;
          end
          state <= IDLE;
        end
      endcase
    end
  end
`ifdef DLRX_FRMCNT_EN
  always_ff @(posedge CLOCK or negedge SIM_RST_n) begin
    if (!SIM_RST_n) begin
      GOOD_CNT <= '0;
      ERR_CNT  <= '0;
    end else begin
      GOOD_CNT <= GOOD_CNT + {7'd0, WORD_VALID};
      ERR_CNT  <= ERR_CNT + {7'd0, FRAME_ERR};
    end
  end
`endif
endmodule

// File: tb/tb_downlink_receiver.sv
// tb_downlink_receiver: directed vectors for downlink_receiver with hand-computed expectations.
module tb_downlink_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dkstrt = 1'b0, dkbsnc = 1'b0, dkdata_n = 1'b1, dkend = 1'b0;
  logic [15:0] ch34, ch35;
  logic word_order, word_valid, frame_err, busy;
`ifdef DLRX_FRMCNT_EN
  logic [7:0] good_cnt, err_cnt;
`endif
  int errors = 0, checks = 0;
  int fe_cnt = 0, wv_cnt = 0;
  int wv_at, fe_at, e0, w0;
  localparam logic [39:0] F1 = {16'h8123, 16'h4567, 8'hA5};
  localparam logic [39:0] F2 = {16'h1111, 16'h2222, 8'hA5};
  localparam logic [39:0] F3 = {16'h1111, 16'h2222, 8'hA4};
  localparam logic [39:0] F4 = {16'h1234, 16'hABCD, 8'hA5};

  downlink_receiver dut (
    .CLOCK(clk), .SIM_RST_n(rst_n), .DKSTRT(dkstrt), .DKBSNC(dkbsnc),
    .DKDATA_n(dkdata_n), .DKEND(dkend), .CH34_OUT(ch34), .CH35_OUT(ch35),
    .WORD_ORDER(word_order), .WORD_VALID(word_valid), .FRAME_ERR(frame_err),
    .BUSY(busy)
`ifdef DLRX_FRMCNT_EN
    , .GOOD_CNT(good_cnt), .ERR_CNT(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (word_valid) wv_cnt <= wv_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    dkstrt = 1'b1;
    repeat (2) @(negedge clk);
    dkstrt = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int hp);
    dkdata_n = ~b;
    dkbsnc = 1'b1;
    repeat (hp) @(negedge clk);
    dkbsnc = 1'b0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f, input int nbits, input int hp);
    logic [39:0] fv;
    fv = f;
    pulse_start();
    for (int i = 0; i < nbits; i++) send_bit(i < 40 ? fv[39-i] : 1'b0, hp);
  endtask

  // raise DKEND and note on which cycle (1-based) each output pulse first appears
  task automatic end_frame();
    wv_at = 0;
    fe_at = 0;
    dkend = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) dkend = 1'b0;
      if (word_valid && wv_at == 0) wv_at = k;
      if (frame_err && fe_at == 0) fe_at = k;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ch34", ch34, 0);
    chk("rst_ch35", ch35, 0);
    chk("rst_order", word_order, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(F1, 40, 3);
    chk("good_busy_shift", busy, 1);
    end_frame();
    chk("good_valid_lat", wv_at, 5);
    chk("good_no_err", fe_at, 0);
    chk("good_ch34", ch34, 16'h8123);
    chk("good_ch35", ch35, 16'h4567);
    chk("good_order", word_order, 1);
    chk("good_busy_idle", busy, 0);

    send_frame(F2, 39, 3);
    end_frame();
    chk("short_err_lat", fe_at, 5);
    chk("short_no_valid", wv_at, 0);
    chk("short_ch34_kept", ch34, 16'h8123);
    chk("short_ch35_kept", ch35, 16'h4567);

    send_frame(F3, 40, 3);
    end_frame();
    chk("badsync_err_lat", fe_at, 5);
    chk("badsync_no_valid", wv_at, 0);
    chk("badsync_ch34_kept", ch34, 16'h8123);

    e0 = fe_cnt;
    w0 = wv_cnt;
    send_frame(F1, 10, 3);
    send_frame(F4, 40, 3);
    end_frame();
    chk("restart_errs", fe_cnt - e0, 1);
    chk("restart_valids", wv_cnt - w0, 1);
    chk("restart_ch34", ch34, 16'h1234);
    chk("restart_ch35", ch35, 16'hABCD);
    chk("restart_order", word_order, 0);

    e0 = fe_cnt;
    w0 = wv_cnt;
    send_frame(F1, 40, 3);
    chk("ovf_none_at_40", fe_cnt - e0, 0);
    send_bit(1'b1, 3);
    repeat (4) @(negedge clk);
    chk("ovf_err", fe_cnt - e0, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_no_valid", wv_cnt - w0, 0);

    send_frame(F1, 5, 3);
    e0 = fe_cnt;
    repeat (4000) @(negedge clk);
    chk("tmo_not_early", fe_cnt - e0, 0);
    chk("tmo_busy_wait", busy, 1);
    for (int k = 0; k < 300 && fe_cnt == e0; k++) @(negedge clk);
    @(negedge clk);
    chk("tmo_err", fe_cnt - e0, 1);
    chk("tmo_busy", busy, 0);

    send_frame(F1, 20, 3);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ch34", ch34, 0);
    chk("mid_rst_ch35", ch35, 0);
    chk("mid_rst_order", word_order, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(F1, 40, 3);
    end_frame();
    chk("after_rst_lat", wv_at, 5);
    chk("after_rst_ch34", ch34, 16'h8123);
    chk("after_rst_ch35", ch35, 16'h4567);

`ifdef DLRX_FRMCNT_EN
    chk("cnt_good_1", good_cnt, 1);
    chk("cnt_err_0", err_cnt, 0);
    for (int n = 0; n < 255; n++) begin
      send_frame(F4, 40, 2);
      end_frame();
    end
    chk("cnt_good_wrap", good_cnt, 0);
    for (int n = 0; n < 3; n++) begin
      send_frame(F3, 40, 2);
      end_frame();
    end
    chk("cnt_err_3", err_cnt, 3);
    chk("cnt_good_hold", good_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
